// File: rtl/exc_addr_ctrl.sv
// exc_addr_ctrl: exception sequencer and owner of the memory address-mux select.
//
// In IDLE the main control unit's address select and write enable pass straight
// through. The write enable is suppressed combinationally in any cycle where an
// exception input is high. An invalid-opcode, overflow or divide-by-zero event
// starts the sequence SAVE -> WAIT (MEM_LAT cycles) -> LOAD:
//   SAVE : pulse epc_wr_o and put the vector select on the address mux.
//   WAIT : hold the vector select while the memory read settles.
//   LOAD : pulse pc_wr_o. exc_target_o holds the handler byte, which was
//          captured on the edge into LOAD.
//
// Optional feature: define EXC_CAUSE_EN to add the exc_cause_o port and register.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   ctrl_sel_i     address-mux select from the main control unit
//   ctrl_mem_wr_i  memory write enable from the main control unit
//   exc_opcode_i   invalid-opcode event (level)
//   exc_overflow_i ALU overflow event (level)
//   exc_div0_i     divide-by-zero event (level)
//   mem_rdata_i    low byte of memory read data
//   mem_addr_sel_o select driven to the address mux
//   mem_wr_o       memory write enable to memory
//   epc_wr_o       EPC write strobe
//   pc_wr_o        PC write strobe for the exception target
//   exc_target_o   handler address, {24'b0, captured byte}
//   exc_cause_o    cause register, 01 opcode / 10 overflow / 11 div0 (EXC_CAUSE_EN only)
//   exc_busy_o     high for the whole sequence; the main control unit stalls

module exc_addr_ctrl #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [2:0]  ctrl_sel_i,
    input  logic        ctrl_mem_wr_i,
    input  logic        exc_opcode_i,
    input  logic        exc_overflow_i,
    input  logic        exc_div0_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [2:0]  mem_addr_sel_o,
    output logic        mem_wr_o,
    output logic        epc_wr_o,
    output logic        pc_wr_o,
    output logic [31:0] exc_target_o,
`ifdef EXC_CAUSE_EN
    output logic [1:0]  exc_cause_o,
`endif
    output logic        exc_busy_o
);

    localparam logic [3:0] CntInit = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSave,
        StWait,
        StLoad
    } state_e;

    state_e     state_q;
    logic [3:0] cnt_q;
    logic [2:0] vec_q;
    logic [7:0] target_q;
    logic       epc_wr_q;
    logic       pc_wr_q;
    logic       busy_q;
`ifdef EXC_CAUSE_EN
    logic [1:0] cause_q;
`endif

    logic       any_exc;
    logic [2:0] win_vec;
    logic [1:0] win_cause;

    // Fixed priority: opcode > overflow > div0. Losers are simply dropped.
    always_comb begin
        any_exc   = exc_opcode_i | exc_overflow_i | exc_div0_i;
        win_vec   = 3'b110;
        win_cause = 2'b11;
        if (exc_opcode_i) begin
            win_vec   = 3'b100;
            win_cause = 2'b01;
        end else if (exc_overflow_i) begin
            win_vec   = 3'b101;
            win_cause = 2'b10;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            vec_q    <= 3'd0;
            target_q <= 8'd0;
            epc_wr_q <= 1'b0;
            pc_wr_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef EXC_CAUSE_EN
            cause_q  <= 2'b00;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_exc) begin
                        state_q  <= StSave;
                        vec_q    <= win_vec;
                        epc_wr_q <= 1'b1;
                        busy_q   <= 1'b1;
`ifdef EXC_CAUSE_EN
                        cause_q  <= win_cause;
`endif
                    end
                end
                StSave: begin
                    state_q  <= StWait;
                    cnt_q    <= CntInit;
                    epc_wr_q <= 1'b0;
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        // Address has been stable for MEM_LAT cycles: data is valid.
                        state_q  <= StLoad;
                        target_q <= mem_rdata_i;
                        pc_wr_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StLoad: begin
                    state_q <= StIdle;
                    pc_wr_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The write is gated combinationally so a write requested in the
    // detection cycle never reaches memory; reset also blocks it.
    always_comb begin
        if (busy_q) begin
            mem_addr_sel_o = vec_q;
            mem_wr_o       = 1'b0;
        end else begin
            mem_addr_sel_o = ctrl_sel_i;
            mem_wr_o       = rst_ni & ctrl_mem_wr_i & ~any_exc;
        end
    end

    assign epc_wr_o     = epc_wr_q;
    assign pc_wr_o      = pc_wr_q;
    assign exc_busy_o   = busy_q;
    assign exc_target_o = {24'b0, target_q};
`ifdef EXC_CAUSE_EN
    assign exc_cause_o  = cause_q;
`else
    logic unused_cause;
    assign unused_cause = ^win_cause;
`endif

endmodule

// File: tb/tb_exc_addr_ctrl.sv
// Bench for exc_addr_ctrl: two instances (MEM_LAT = 2 and 1) share the stimulus
// and are compared every cycle against a sequence-position reference model.

module tb_exc_addr_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] ctrl_sel;
    logic       ctrl_wr;
    logic       e_op;
    logic       e_ov;
    logic       e_d0;
    logic [7:0] rdata;

    logic [2:0]  sel_o  [2];
    logic        mwr_o  [2];
    logic        epc_o  [2];
    logic        pc_o   [2];
    logic        busy_o [2];
    logic [31:0] tgt_o  [2];
`ifdef EXC_CAUSE_EN
    logic [1:0]  cause_o [2];
`endif

    exc_addr_ctrl #(.MEM_LAT(2)) u_lat2 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .ctrl_sel_i     (ctrl_sel),
        .ctrl_mem_wr_i  (ctrl_wr),
        .exc_opcode_i   (e_op),
        .exc_overflow_i (e_ov),
        .exc_div0_i     (e_d0),
        .mem_rdata_i    (rdata),
        .mem_addr_sel_o (sel_o[0]),
        .mem_wr_o       (mwr_o[0]),
        .epc_wr_o       (epc_o[0]),
        .pc_wr_o        (pc_o[0]),
        .exc_target_o   (tgt_o[0]),
`ifdef EXC_CAUSE_EN
        .exc_cause_o    (cause_o[0]),
`endif
        .exc_busy_o     (busy_o[0])
    );

    exc_addr_ctrl #(.MEM_LAT(1)) u_lat1 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .ctrl_sel_i     (ctrl_sel),
        .ctrl_mem_wr_i  (ctrl_wr),
        .exc_opcode_i   (e_op),
        .exc_overflow_i (e_ov),
        .exc_div0_i     (e_d0),
        .mem_rdata_i    (rdata),
        .mem_addr_sel_o (sel_o[1]),
        .mem_wr_o       (mwr_o[1]),
        .epc_wr_o       (epc_o[1]),
        .pc_wr_o        (pc_o[1]),
        .exc_target_o   (tgt_o[1]),
`ifdef EXC_CAUSE_EN
        .exc_cause_o    (cause_o[1]),
`endif
        .exc_busy_o     (busy_o[1])
    );

    // Model: pos = -1 when idle, else index within the busy window
    // (0 = save cycle, 1..lat = wait cycles, lat+1 = load cycle).
    int         lat   [2] = '{2, 1};
    int         pos   [2];
    logic [2:0] m_vec [2];
    logic [7:0] m_tgt [2];
    logic [1:0] m_cause [2];
    int         pc_cnt [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            pos[d]     = -1;
            m_vec[d]   = 3'd0;
            m_tgt[d]   = 8'd0;
            m_cause[d] = 2'd0;
        end
    endtask

    task automatic model_edge();
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (pos[d] < 0) begin
                    if (e_op) begin
                        pos[d] = 0; m_vec[d] = 3'b100; m_cause[d] = 2'b01;
                    end else if (e_ov) begin
                        pos[d] = 0; m_vec[d] = 3'b101; m_cause[d] = 2'b10;
                    end else if (e_d0) begin
                        pos[d] = 0; m_vec[d] = 3'b110; m_cause[d] = 2'b11;
                    end
                end else if (pos[d] == lat[d] + 1) begin
                    pos[d] = -1;
                end else begin
                    if (pos[d] == lat[d]) m_tgt[d] = rdata;
                    pos[d]++;
                end
            end
        end
    endtask

    task automatic check_all();
        logic       b;
        logic [2:0] s;
        logic       w;
        for (int d = 0; d < 2; d++) begin
            b = (pos[d] >= 0);
            s = b ? m_vec[d] : ctrl_sel;
            w = rst_n && !b && ctrl_wr && !(e_op || e_ov || e_d0);
            chk($sformatf("d%0d busy", d), 32'(busy_o[d]), 32'(b));
            chk($sformatf("d%0d sel", d), 32'(sel_o[d]), 32'(s));
            chk($sformatf("d%0d mem_wr", d), 32'(mwr_o[d]), 32'(w));
            chk($sformatf("d%0d epc_wr", d), 32'(epc_o[d]), 32'(pos[d] == 0));
            chk($sformatf("d%0d pc_wr", d), 32'(pc_o[d]), 32'(pos[d] == lat[d] + 1));
            chk($sformatf("d%0d target", d), tgt_o[d], {24'b0, m_tgt[d]});
`ifdef EXC_CAUSE_EN
            chk($sformatf("d%0d cause", d), 32'(cause_o[d]), 32'(m_cause[d]));
`endif
            if (pc_o[d]) pc_cnt[d]++;
        end
    endtask

    task automatic step(input logic r, input logic [2:0] sel, input logic wr,
                        input logic op, input logic ov, input logic d0, input logic [7:0] rd);
        @(negedge clk);
        rst_n    = r;
        ctrl_sel = sel;
        ctrl_wr  = wr;
        e_op     = op;
        e_ov     = ov;
        e_d0     = d0;
        rdata    = rd;
        if (!r) model_reset();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        rst_n = 1'b0; ctrl_sel = 3'd0; ctrl_wr = 1'b0;
        e_op = 1'b0; e_ov = 1'b0; e_d0 = 1'b0; rdata = 8'd0;
        pc_cnt = '{0, 0};
        model_reset();

        // Reset state, with a write request that must not get through.
        step(1'b0, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Passthrough, including the vector encodings issued by control.
        step(1'b1, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Overflow sequence, handler byte 0x40.
        step(1'b1, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 8'h40);
        for (int i = 0; i < 5; i++) step(1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40);
        #2;
        chk("ovf target lat2", tgt_o[0], 32'h0000_0040);
        chk("ovf target lat1", tgt_o[1], 32'h0000_0040);
        chk("ovf one pc_wr lat2", 32'(pc_cnt[0]), 32'd1);
`ifdef EXC_CAUSE_EN
        chk("ovf cause", 32'(cause_o[0]), 32'd2);
`endif

        // All three together with a write request; div0 raised again during wait.
        pc_cnt = '{0, 0};
        step(1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 8'h12);
        step(1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12);
        step(1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12);
        for (int i = 0; i < 5; i++) step(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12);
        #2;
        chk("nest one pc_wr lat2", 32'(pc_cnt[0]), 32'd1);
        chk("nest target lat2", tgt_o[0], 32'h0000_0012);
`ifdef EXC_CAUSE_EN
        chk("prio cause", 32'(cause_o[0]), 32'd1);
`endif

        // Reset in the middle of the wait window.
        pc_cnt = '{0, 0};
        step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
        step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77);
        step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77);
        step(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77);
        for (int i = 0; i < 4; i++) step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77);
        #2;
        chk("rst no pc_wr lat2", 32'(pc_cnt[0]), 32'd0);
        chk("rst target lat2", tgt_o[0], 32'h0);

        // Divide-by-zero, handler byte 0xFF.
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 5; i++) step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
        #2;
        chk("div0 target lat1", tgt_o[1], 32'h0000_00FF);

        // Randomized traffic, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) != 0),
                 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0),
                 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
